// File: rtl/pas_daemon_scheduler.sv
// Round-robin front end sharing one pas_daemons unit; energy trip drains the daemon, then holds a Landauer cool-down window.
// Latency: grant at t -> dmn_valid t+1 -> rsp t+2+DAEMON_LAT. Backpressure: req_ready is a combinational one-hot grant, zero outside RUN; responses have none.
// Optional: PAS_SCHED_STATS_EN enables the saturating sink_count; otherwise sink_count is tied to 0.
module pas_daemon_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int          ID_W        = 2,
  parameter int          DAEMON_LAT  = 1,
  parameter logic [31:0] ENERGY_HI   = 32'hF0000000,
  parameter int          COOL_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_entropy,
  input  logic [NUM_REQ*32-1:0]   req_work,
  output logic                    dmn_valid,
  output logic [31:0]             dmn_entropy,
  output logic [31:0]             dmn_work,
  input  logic [1:0]              dmn_gate,
  input  logic [31:0]             dmn_energy,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [1:0]              rsp_gate,
  output logic                    landauer_req,
  output logic [1:0]              sched_state,
  output logic [15:0]             sink_count
);

  localparam int CNT_W = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_COOL  = 2'b10;

  logic [1:0]               r_state;
  logic [ID_W-1:0]          r_ptr;
  logic [CNT_W-1:0]         r_cool_cnt;
  logic                     r_dmn_valid;
  logic [31:0]              r_dmn_entropy;
  logic [31:0]              r_dmn_work;
  logic [ID_W-1:0]          r_iss_id;
  logic [DAEMON_LAT-1:0]    r_tag_vld;
  logic [DAEMON_LAT*ID_W-1:0] r_tag_id;
  logic                     r_rsp_valid;
  logic [ID_W-1:0]          r_rsp_id;
  logic [1:0]               r_rsp_gate;

  logic                     w_run;
  logic                     w_grant_vld;
  logic                     w_hs;
  logic                     w_trip;
  logic                     w_drained;
  int                       w_grant_idx;
  int                       w_scan;
  logic [NUM_REQ-1:0]       w_ready;
  logic [31:0]              w_sel_entropy;
  logic [31:0]              w_sel_work;
  logic [ID_W-1:0]          w_ptr_nxt;
  logic [DAEMON_LAT:0]      w_tag_vld_in;
  logic [(DAEMON_LAT+1)*ID_W-1:0] w_tag_id_in;

  // Reset input gates the grant so req_ready is 0 while reset is held.
  assign w_run = (r_state == ST_RUN) & reset;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 0;
    w_scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant_vld && (w_scan == i) && req_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = i;
        end
      end
    end
  end

  always_comb begin
    w_ready       = '0;
    w_sel_entropy = '0;
    w_sel_work    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == i) begin
        w_sel_entropy = req_entropy[32*i +: 32];
        w_sel_work    = req_work[32*i +: 32];
        w_ready[i]    = w_run & w_grant_vld;
      end
    end
  end

  assign req_ready    = w_ready;
  assign w_hs         = w_run & w_grant_vld;
  assign w_ptr_nxt    = (w_grant_idx == NUM_REQ - 1) ? '0 : ID_W'(w_grant_idx + 1);
  assign w_trip       = dmn_energy > ENERGY_HI;
  assign w_drained    = !r_dmn_valid && !(|r_tag_vld);
  assign w_tag_vld_in = {r_tag_vld, r_dmn_valid};
  assign w_tag_id_in  = {r_tag_id, r_iss_id};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_cool_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_trip) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state    <= ST_COOL;
            r_cool_cnt <= CNT_W'(COOL_CYCLES - 1);
          end
        end
        ST_COOL: begin
          if (r_cool_cnt == '0) r_state <= ST_RUN;
          else                  r_cool_cnt <= r_cool_cnt - CNT_W'(1);
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr         <= '0;
      r_dmn_valid   <= 1'b0;
      r_dmn_entropy <= '0;
      r_dmn_work    <= '0;
      r_iss_id      <= '0;
    end else begin
      r_dmn_valid <= w_hs;
      if (w_hs) begin
        r_ptr         <= w_ptr_nxt;
        r_dmn_entropy <= w_sel_entropy;
        r_dmn_work    <= w_sel_work;
        r_iss_id      <= ID_W'(w_grant_idx);
      end
    end
  end

  // Tag shift register: the oldest stage lines up with dmn_gate for its sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld <= w_tag_vld_in[DAEMON_LAT-1:0];
      r_tag_id  <= w_tag_id_in[DAEMON_LAT*ID_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_gate  <= 2'b01;
    end else begin
      r_rsp_valid <= r_tag_vld[DAEMON_LAT-1];
      if (r_tag_vld[DAEMON_LAT-1]) begin
        r_rsp_id   <= r_tag_id[DAEMON_LAT*ID_W-1 -: ID_W];
        r_rsp_gate <= dmn_gate;
      end
    end
  end

  assign dmn_valid    = r_dmn_valid;
  assign dmn_entropy  = r_dmn_entropy;
  assign dmn_work     = r_dmn_work;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_gate     = r_rsp_gate;
  assign landauer_req = (r_state == ST_COOL);
  assign sched_state  = r_state;

`ifdef PAS_SCHED_STATS_EN
  logic [15:0] r_sink_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sink_count <= '0;
    end else if (r_rsp_valid && (r_rsp_gate == 2'b00) && (r_sink_count != 16'hFFFF)) begin
      r_sink_count <= r_sink_count + 16'd1;
    end
  end

  assign sink_count = r_sink_count;
`else
  assign sink_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pas_daemon_scheduler.sv
// Randomized bench for pas_daemon_scheduler: a transaction-level model (pending-response queue, cycle-counted cool window) predicts every output.
module tb_pas_daemon_scheduler;

  localparam int          N    = 4;
  localparam int          COOL = 16;
  localparam logic [31:0] EHI  = 32'hF0000000;
`ifdef PAS_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_entropy;
  logic [N*32-1:0] req_work;
  logic            dmn_valid;
  logic [31:0]     dmn_entropy;
  logic [31:0]     dmn_work;
  logic [1:0]      dmn_gate;
  logic [31:0]     dmn_energy;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [1:0]      rsp_gate;
  logic            landauer_req;
  logic [1:0]      sched_state;
  logic [15:0]     sink_count;

  pas_daemon_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_entropy  (req_entropy),
    .req_work     (req_work),
    .dmn_valid    (dmn_valid),
    .dmn_entropy  (dmn_entropy),
    .dmn_work     (dmn_work),
    .dmn_gate     (dmn_gate),
    .dmn_energy   (dmn_energy),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_gate     (rsp_gate),
    .landauer_req (landauer_req),
    .sched_state  (sched_state),
    .sink_count   (sink_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         id;
    logic [1:0] gate;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // staged inputs, applied at the next falling edge
  logic [N-1:0] nxt_valid;
  logic [31:0]  nxt_energy;
  logic         nxt_rst;
  logic [31:0]  ent_a [N];
  logic [31:0]  wrk_a [N];

  // reference model
  int          cyc;
  int          m_state;
  int          m_ptr;
  int          m_cool;
  logic        m_dvld;
  logic [31:0] m_ent;
  logic [31:0] m_wrk;
  logic [1:0]  m_last_gate;
  int          m_sink;
  rsp_t        q[$];
  logic [1:0]  d_pending;

  int   lcount;
  logic prev_land;
  int   prev_state;
  bit   p5;
  bit   arm;
  int   run_grants;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] sort_gate(input logic [31:0] e, input logic [31:0] w);
    if (e > w)      return 2'b10;
    else if (e < w) return 2'b00;
    else            return 2'b01;
  endfunction

  task automatic model_reset();
    m_state     = 0;
    m_ptr       = 0;
    m_cool      = 0;
    m_dvld      = 1'b0;
    m_ent       = '0;
    m_wrk       = '0;
    m_last_gate = 2'b01;
    m_sink      = 0;
    q.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      ent_a[i] = $urandom;
      wrk_a[i] = $urandom;
    end
  endtask

  task automatic step();
    int         g;
    int         idx;
    logic [N-1:0] exp_rdy;
    logic       exp_rv;
    logic       hs_obs;
    rsp_t       item;
    @(negedge clk);
    // daemon: answers one cycle after it sees dmn_valid
    dmn_gate = d_pending;
    if (dmn_valid) d_pending = sort_gate(dmn_entropy, dmn_work);
    else           d_pending = 2'($urandom_range(0, 3));
    reset      = nxt_rst;
    req_valid  = nxt_valid;
    dmn_energy = nxt_energy;
    for (int i = 0; i < N; i++) begin
      req_entropy[32*i +: 32] = ent_a[i];
      req_work[32*i +: 32]    = wrk_a[i];
    end
    #1;
    if (!reset) model_reset();

    g = -1;
    if (reset && m_state == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    chk("req_ready",   32'(req_ready), 32'(exp_rdy));
    chk("dmn_valid",   32'(dmn_valid), 32'(m_dvld));
    chk("dmn_entropy", dmn_entropy, m_ent);
    chk("dmn_work",    dmn_work, m_wrk);
    chk("sched_state", 32'(sched_state), 32'(m_state));
    chk("landauer",    32'(landauer_req), 32'(m_state == 2));
    chk("sink_count",  32'(sink_count), STATS ? 32'(m_sink) : 32'd0);
    if (!reset) chk("rsp_id_rst", 32'(rsp_id), 32'd0);

    exp_rv = (q.size() > 0) && (q[0].due == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      m_last_gate = q[0].gate;
      if (q[0].gate == 2'b00 && m_sink < 65535) m_sink++;
      void'(q.pop_front());
    end
    chk("rsp_gate", 32'(rsp_gate), 32'(m_last_gate));

    // landauer window length, measured on the DUT's own pulse
    if (landauer_req) lcount++;
    else begin
      if (prev_land) chk("cool_len", 32'(lcount), 32'(COOL));
      lcount = 0;
    end
    prev_land = landauer_req;

    hs_obs = |(req_valid & req_ready);
    if (p5) begin
      if (sched_state == 2'b00 && prev_state != 0) begin
        arm        = 1'b1;
        run_grants = 0;
      end
      if (sched_state == 2'b00 && hs_obs) run_grants++;
      if (sched_state != 2'b00 && prev_state == 0 && arm) chk("run_grants", 32'(run_grants), 32'd1);
    end
    prev_state = int'(sched_state);

    if (reset) begin
      m_dvld = (g >= 0);
      if (g >= 0) begin
        m_ent     = ent_a[g];
        m_wrk     = wrk_a[g];
        item.due  = cyc + 3;
        item.id   = g;
        item.gate = sort_gate(ent_a[g], wrk_a[g]);
        q.push_back(item);
        m_ptr = (g + 1) % N;
      end
      case (m_state)
        0: if (dmn_energy > EHI) m_state = 1;
        1: if (q.size() == 0) begin
             m_state = 2;
             m_cool  = COOL;
           end
        default: begin
          m_cool--;
          if (m_cool == 0) m_state = 0;
        end
      endcase
    end
    cyc++;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_entropy = '0;
    req_work    = '0;
    dmn_gate    = 2'b00;
    dmn_energy  = '0;
    d_pending   = 2'b00;
    nxt_valid   = '0;
    nxt_energy  = '0;
    nxt_rst     = 1'b0;
    for (int i = 0; i < N; i++) begin
      ent_a[i] = '0;
      wrk_a[i] = '0;
    end
    cyc        = 0;
    lcount     = 0;
    prev_land  = 1'b0;
    prev_state = 0;
    p5         = 1'b0;
    arm        = 1'b0;
    run_grants = 0;
    model_reset();

    // post-reset idle
    repeat (3) step();
    nxt_rst = 1'b1;
    repeat (20) step();

    // single request on requester 2, daemon answers source
    nxt_valid = 4'b0100;
    ent_a[2]  = 32'h100;
    wrk_a[2]  = 32'h40;
    step();
    nxt_valid = '0;
    repeat (6) step();

    // round-robin with all requesters active
    nxt_valid = 4'hF;
    repeat (8) begin
      rand_data();
      step();
    end
    nxt_valid = '0;
    repeat (5) step();

    // energy trip with two samples in flight
    nxt_valid = 4'hF;
    repeat (2) begin
      rand_data();
      step();
    end
    nxt_valid  = '0;
    nxt_energy = 32'hF0000001;
    step();
    nxt_energy = '0;
    nxt_valid  = 4'hF;
    repeat (30) begin
      rand_data();
      step();
    end
    nxt_energy = EHI;
    repeat (20) begin
      rand_data();
      step();
    end

    // persistent high energy
    p5         = 1'b1;
    arm        = 1'b0;
    nxt_energy = 32'hFFFFFFFF;
    repeat (100) begin
      rand_data();
      step();
    end
    p5         = 1'b0;
    nxt_energy = '0;
    nxt_valid  = '0;
    repeat (30) step();

    // reset while samples are in flight
    nxt_valid = 4'b0010;
    rand_data();
    step();
    nxt_valid = 4'b1000;
    rand_data();
    step();
    nxt_valid = '0;
    nxt_rst   = 1'b0;
    repeat (3) step();
    nxt_rst = 1'b1;
    repeat (10) step();

    // five sink results
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) begin
        ent_a[i] = 32'h10 + 32'(k);
        wrk_a[i] = 32'h20;
      end
      nxt_valid = 4'(1 << (k % N));
      step();
    end
    nxt_valid = '0;
    repeat (8) step();
    chk("sink5", 32'(sink_count), STATS ? 32'd5 : 32'd0);

    // random traffic with occasional trips and boundary energy
    repeat (400) begin
      int r;
      rand_data();
      nxt_valid = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 2)      nxt_energy = 32'hFFFFFFFF;
      else if (r < 4) nxt_energy = EHI + 32'd1;
      else if (r < 8) nxt_energy = EHI;
      else            nxt_energy = $urandom & 32'h7FFFFFFF;
      step();
    end
    nxt_valid  = '0;
    nxt_energy = '0;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
